// File: rtl/hgcal_input_packer.sv
// HGCAL autoencoder front end: quantizes a serial sample stream and
// packs each frame into a double-buffered flat vector for layer 0.
module hgcal_input_packer #(
  parameter int N_IN  = 48,
  parameter int W_IN  = 10,
  parameter int W_Q   = 2,
  parameter int SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W_IN-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_IN*W_Q-1:0]   m_data,
  output logic                  err_frame
);

  localparam int IW = $clog2(N_IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [W_IN-1:0] QMAX = W_IN'((1 << W_Q) - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [N_IN*W_Q-1:0] r_fill;
  logic [N_IN*W_Q-1:0] r_out;
  logic                r_m_valid;
  logic                r_err;

  logic [W_IN-1:0]     w_t;
  logic [W_Q-1:0]      w_q;
  logic                w_acc;
  logic                w_take;
  logic                w_room;
  logic [N_IN*W_Q-1:0] w_fill_next;

  assign w_t    = s_data >> SHIFT;
  assign w_q    = (w_t > QMAX) ? QMAX[W_Q-1:0] : w_t[W_Q-1:0];
  assign s_ready = (r_state != HOLD);
  assign w_acc  = s_valid && s_ready;
  assign w_take = r_m_valid && m_ready;
  assign w_room = !r_m_valid || m_ready;

  // Commit must see the sample being written on this same edge.
  always_comb begin
    w_fill_next = r_fill;
    w_fill_next[r_idx*W_Q +: W_Q] = w_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FILL;
      r_idx     <= '0;
      r_fill    <= '0;
      r_out     <= '0;
      r_m_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_take) r_m_valid <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_acc) begin
            r_fill <= w_fill_next;
            if (r_idx != LAST_IDX) begin
              if (s_last) begin
                r_err <= 1'b1;
                r_idx <= '0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else if (s_last) begin
              r_idx <= '0;
              if (w_room) begin
                r_out     <= w_fill_next;
                r_m_valid <= 1'b1;
              end else begin
                r_state <= HOLD;
              end
            end else begin
              r_err   <= 1'b1;
              r_idx   <= '0;
              r_state <= DISCARD;
            end
          end
        end
        HOLD: begin
          if (w_take) begin
            r_out     <= r_fill;
            r_m_valid <= 1'b1;
            r_idx     <= '0;
            r_state   <= FILL;
          end
        end
        DISCARD: begin
          if (w_acc && s_last) begin
            r_idx   <= '0;
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_out;
  assign err_frame = r_err;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed + randomized checks of hgcal_input_packer against a
// frame-level model (quantize each sample, place it in its slot).
module tb_hgcal_input_packer;

  localparam int N  = 48;
  localparam int VW = N * 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [9:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [VW-1:0] m_data;
  logic          err_frame;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int unsigned smp [64];

  hgcal_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_frame) err_cnt++;

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model();
    logic [VW-1:0] v;
    int unsigned q;
    v = '0;
    for (int i = 0; i < N; i++) begin
      q = smp[i] / 16;
      if (q > 3) q = 3;
      v[i*2 +: 2] = 2'(q);
    end
    return v;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < 64; i++) smp[i] = $urandom_range(0, 1023);
  endtask

  task automatic send_sample(input int unsigned d, input bit last);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 10'(d);
    s_last  = last;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $error("FAIL s_ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) send_sample(smp[i], i == len - 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] ea;
    logic [VW-1:0] eb;
    logic [VW-1:0] md;
    int e0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", VW'(m_valid), VW'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_s_ready", VW'(s_ready), VW'(1));
    chk("rst_err", VW'(err_frame), VW'(0));
    @(negedge clk);
    rst = 1'b0;

    // Ramp frame, downstream always ready
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) smp[i] = i * 21;
    ea = model();
    send_frame(N);
    chk("ramp_valid", VW'(m_valid), VW'(1));
    chk("ramp_data", m_data, ea);
    md = m_data;
    chk("ramp_slot0", VW'(md[1:0]), VW'(0));
    chk("ramp_slot1", VW'(md[3:2]), VW'(1));
    chk("ramp_slot2", VW'(md[5:4]), VW'(2));
    chk("ramp_slot3", VW'(md[7:6]), VW'(3));
    chk("ramp_slot47", VW'(md[95:94]), VW'(3));
    step();
    chk("ramp_drain", VW'(m_valid), VW'(0));
    chk("ramp_hold_data", m_data, ea);

    // Quantizer edges
    rand_frame();
    smp[0] = 'h00F; smp[1] = 'h010; smp[2] = 'h020;
    smp[3] = 'h030; smp[4] = 'h3FF;
    ea = model();
    send_frame(N);
    md = m_data;
    chk("q_00F", VW'(md[1:0]), VW'(0));
    chk("q_010", VW'(md[3:2]), VW'(1));
    chk("q_020", VW'(md[5:4]), VW'(2));
    chk("q_030", VW'(md[7:6]), VW'(3));
    chk("q_3FF", VW'(md[9:8]), VW'(3));
    chk("q_frame", m_data, ea);

    // Back-pressure: two frames, second goes to HOLD
    step();
    m_ready = 1'b0;
    rand_frame();
    ea = model();
    send_frame(N);
    chk("bp_a_valid", VW'(m_valid), VW'(1));
    chk("bp_a_data", m_data, ea);
    rand_frame();
    eb = model();
    send_frame(N);
    chk("bp_hold_ready", VW'(s_ready), VW'(0));
    chk("bp_hold_data", m_data, ea);
    step();
    chk("bp_hold_ready2", VW'(s_ready), VW'(0));
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_b_data", m_data, eb);
    chk("bp_b_valid", VW'(m_valid), VW'(1));
    chk("bp_release", VW'(s_ready), VW'(1));
    step();
    chk("bp_b_keep", VW'(m_valid), VW'(1));
    @(negedge clk);
    m_ready = 1'b1;
    step();
    chk("bp_b_drain", VW'(m_valid), VW'(0));

    // Short frame then a good frame
    e0 = err_cnt;
    rand_frame();
    send_frame(11);
    chk("short_err", VW'(err_frame), VW'(1));
    chk("short_no_valid", VW'(m_valid), VW'(0));
    step();
    chk("short_err_once", VW'(err_cnt - e0), VW'(1));
    rand_frame();
    ea = model();
    send_frame(N);
    chk("short_next_valid", VW'(m_valid), VW'(1));
    chk("short_next_data", m_data, ea);
    step();

    // Long frame: 50 samples
    e0 = err_cnt;
    rand_frame();
    send_frame(50);
    chk("long_no_valid", VW'(m_valid), VW'(0));
    step();
    chk("long_err_once", VW'(err_cnt - e0), VW'(1));
    rand_frame();
    ea = model();
    send_frame(N);
    chk("long_next_valid", VW'(m_valid), VW'(1));
    chk("long_next_data", m_data, ea);
    step();

    // Reset mid-frame with a full output held
    m_ready = 1'b0;
    rand_frame();
    send_frame(N);
    for (int i = 0; i < 20; i++) send_sample($urandom_range(0, 1023), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", VW'(m_valid), VW'(0));
    chk("rstmid_data", m_data, '0);
    chk("rstmid_ready", VW'(s_ready), VW'(1));
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    rand_frame();
    ea = model();
    send_frame(N);
    chk("rstmid_next", m_data, ea);
    chk("rstmid_next_v", VW'(m_valid), VW'(1));
    step();

    // Reset while in HOLD
    m_ready = 1'b0;
    rand_frame();
    send_frame(N);
    rand_frame();
    send_frame(N);
    chk("rsthold_pre", VW'(s_ready), VW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rsthold_valid", VW'(m_valid), VW'(0));
    chk("rsthold_data", m_data, '0);
    chk("rsthold_ready", VW'(s_ready), VW'(1));
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    rand_frame();
    ea = model();
    send_frame(N);
    chk("rsthold_next", m_data, ea);

    // Random back-to-back frames, downstream always ready
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      ea = model();
      send_frame(N);
      chk($sformatf("b2b_%0d", f), m_data, ea);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
